// File: rtl/alu_operand_issue_pkg.sv
// Shared ALU issue definitions: datapath widths, ALU op encodings and a
// saturating counter helper.
package alu_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_operand_issue_if.sv
// Decoder-side and ALU-side handshake bundle of the operand issue register.
interface alu_operand_issue_if;
  import alu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_rs_data;
  logic [DW-1:0] in_rt_data;
  logic [DW-1:0] in_imm;
  logic          in_use_imm;
  logic [2:0]    in_signal;
  logic [4:0]    in_shamt;
  logic [RW-1:0] in_rs_idx;
  logic [RW-1:0] in_rt_idx;
  logic [RW-1:0] in_rd_idx;
  logic          in_reg_write;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dataA;
  logic [DW-1:0] dataB;
  logic [2:0]    Signal;
  logic [4:0]    shamt;
  logic [RW-1:0] out_rd_idx;
  logic          out_reg_write;

  modport master (
    output in_valid, in_rs_data, in_rt_data, in_imm, in_use_imm, in_signal,
           in_shamt, in_rs_idx, in_rt_idx, in_rd_idx, in_reg_write, out_ready,
    input  in_ready, out_valid, dataA, dataB, Signal, shamt, out_rd_idx,
           out_reg_write
  );

  modport slave (
    input  in_valid, in_rs_data, in_rt_data, in_imm, in_use_imm, in_signal,
           in_shamt, in_rs_idx, in_rt_idx, in_rd_idx, in_reg_write, out_ready,
    output in_ready, out_valid, dataA, dataB, Signal, shamt, out_rd_idx,
           out_reg_write
  );

endinterface

// File: rtl/alu_operand_issue_fwd_mux.sv
// Three-source forwarding select: EX/MEM beats MEM/WB beats the register value,
// and register $0 always reads as zero.
module fwd_mux
  import alu_pkg::*;
(
  input  logic [RW-1:0] i_idx,
  input  logic [DW-1:0] i_val,
  input  logic          i_exmem_wr,
  input  logic [RW-1:0] i_exmem_rd,
  input  logic [DW-1:0] i_exmem_res,
  input  logic          i_memwb_wr,
  input  logic [RW-1:0] i_memwb_rd,
  input  logic [DW-1:0] i_memwb_res,
  output logic [DW-1:0] o_data,
  output logic          o_hit
);

  always_comb begin
    o_data = i_val;
    o_hit  = 1'b0;
    if (i_idx == '0) begin
      o_data = '0;
    end else if (i_exmem_wr && (i_exmem_rd == i_idx)) begin
      o_data = i_exmem_res;
      o_hit  = 1'b1;
    end else if (i_memwb_wr && (i_memwb_rd == i_idx)) begin
      o_data = i_memwb_res;
      o_hit  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_issue.sv
// ID/EX operand issue register feeding the ALU, with capture-time forwarding
// and per-cycle re-forwarding while stalled. ALU_ISSUE_PERF_CNT_EN adds
// stall and forward counters.
module alu_operand_issue
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                exmem_wr,
  input  logic [RW-1:0]       exmem_rd,
  input  logic [DW-1:0]       exmem_res,
  input  logic                memwb_wr,
  input  logic [RW-1:0]       memwb_rd,
  input  logic [DW-1:0]       memwb_res,
  alu_operand_issue_if.slave  bus
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]         perf_stall_cyc,
  output logic [15:0]         perf_fwd_cnt
`endif
);

  localparam int NFWD = 4;

  logic          r_valid;
  logic [DW-1:0] r_dataA, r_dataB, r_imm;
  logic [2:0]    r_signal;
  logic [4:0]    r_shamt;
  logic [RW-1:0] r_rd_idx, r_rs_idx, r_rt_idx;
  logic          r_reg_write, r_use_imm;

  logic w_in_ready, w_cap, w_hold, w_drain;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_cap      = bus.in_valid && w_in_ready && !flush;
  assign w_hold     = r_valid && !bus.out_ready;
  assign w_drain    = r_valid && bus.out_ready;

  // Slots 0/1 resolve the incoming rs/rt; slots 2/3 refresh the held operands,
  // with the held value standing in for the register read.
  logic [NFWD-1:0][RW-1:0] w_fidx;
  logic [NFWD-1:0][DW-1:0] w_fval, w_fdat;
  logic [NFWD-1:0]         w_fhit;

  assign w_fidx = {r_rt_idx, r_rs_idx, bus.in_rt_idx, bus.in_rs_idx};
  assign w_fval = {r_dataB, r_dataA, bus.in_rt_data, bus.in_rs_data};

  genvar g;
  generate
    for (g = 0; g < NFWD; g++) begin : gen_fwd
      fwd_mux u_fwd (
        .i_idx       (w_fidx[g]),
        .i_val       (w_fval[g]),
        .i_exmem_wr  (exmem_wr),
        .i_exmem_rd  (exmem_rd),
        .i_exmem_res (exmem_res),
        .i_memwb_wr  (memwb_wr),
        .i_memwb_rd  (memwb_rd),
        .i_memwb_res (memwb_res),
        .o_data      (w_fdat[g]),
        .o_hit       (w_fhit[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_dataA     <= '0;
      r_dataB     <= '0;
      r_imm       <= '0;
      r_signal    <= '0;
      r_shamt     <= '0;
      r_rd_idx    <= '0;
      r_rs_idx    <= '0;
      r_rt_idx    <= '0;
      r_reg_write <= 1'b0;
      r_use_imm   <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_cap) begin
      r_valid     <= 1'b1;
      r_dataA     <= w_fdat[0];
      r_dataB     <= bus.in_use_imm ? bus.in_imm : w_fdat[1];
      r_imm       <= bus.in_imm;
      r_signal    <= bus.in_signal;
      r_shamt     <= bus.in_shamt;
      r_rd_idx    <= bus.in_rd_idx;
      r_rs_idx    <= bus.in_rs_idx;
      r_rt_idx    <= bus.in_rt_idx;
      r_reg_write <= bus.in_reg_write;
      r_use_imm   <= bus.in_use_imm;
    end else if (w_hold) begin
      r_dataA <= w_fdat[2];
      r_dataB <= r_use_imm ? r_imm : w_fdat[3];
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_valid;
  assign bus.dataA         = r_dataA;
  assign bus.dataB         = r_dataB;
  assign bus.Signal        = r_signal;
  assign bus.shamt         = r_shamt;
  assign bus.out_rd_idx    = r_rd_idx;
  assign bus.out_reg_write = r_reg_write;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0] r_stall_cyc, r_fwd_cnt;
  logic        w_fwd_any;

  // An immediate-sourced dataB is not a forward even if rt happens to match.
  assign w_fwd_any = w_fhit[0] || (w_fhit[1] && !bus.in_use_imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cyc <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_hold)              r_stall_cyc <= sat_inc16(r_stall_cyc);
      if (w_cap && w_fwd_any)  r_fwd_cnt   <= sat_inc16(r_fwd_cnt);
    end
  end

  assign perf_stall_cyc = r_stall_cyc;
  assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: directed issues push hand-computed
// results; a negedge monitor pops and compares on every ALU-side transfer.
module tb_alu_operand_issue;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sig;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        exmem_wr = 1'b0;
  logic [4:0]  exmem_rd = '0;
  logic [31:0] exmem_res = '0;
  logic        memwb_wr = 1'b0;
  logic [4:0]  memwb_rd = '0;
  logic [31:0] memwb_res = '0;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t e;

  alu_operand_issue_if bus ();

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0] perf_stall_cyc, perf_fwd_cnt;
`endif

  alu_operand_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .exmem_wr  (exmem_wr),
    .exmem_rd  (exmem_rd),
    .exmem_res (exmem_res),
    .memwb_wr  (memwb_wr),
    .memwb_rd  (memwb_rd),
    .memwb_res (memwb_res),
    .bus       (bus)
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic ui,
                       input logic [2:0] sig, input logic [4:0] sh,
                       input logic [4:0] rd, input logic rw);
    bus.in_valid     = 1'b1;
    bus.in_rs_idx    = rs;
    bus.in_rs_data   = rsd;
    bus.in_rt_idx    = rt;
    bus.in_rt_data   = rtd;
    bus.in_imm       = imm;
    bus.in_use_imm   = ui;
    bus.in_signal    = sig;
    bus.in_shamt     = sh;
    bus.in_rd_idx    = rd;
    bus.in_reg_write = rw;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] sig, input logic [4:0] sh,
                      input logic [4:0] rd, input logic rw);
    exp_t x;
    x.a = a; x.b = b; x.sig = sig; x.sh = sh; x.rd = rd; x.rw = rw;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture edge, drop in_valid, then let the monitor see the transfer.
  task automatic xfer();
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_dataA", bus.dataA, e.a);
        chk("sb_dataB", bus.dataB, e.b);
        chk("sb_Signal", {29'd0, bus.Signal}, {29'd0, e.sig});
        chk("sb_shamt", {27'd0, bus.shamt}, {27'd0, e.sh});
        chk("sb_rd", {27'd0, bus.out_rd_idx}, {27'd0, e.rd});
        chk("sb_rw", {31'd0, bus.out_reg_write}, {31'd0, e.rw});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] sigs [4];
    sigs[0] = ALU_ADD; sigs[1] = ALU_SUB; sigs[2] = ALU_SLT; sigs[3] = ALU_SLL;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_dataA", bus.dataA, 32'd0);
    chk("rst_dataB", bus.dataB, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #14 rst_n = 1'b1;
    step();

    // EX/MEM beats MEM/WB for the same index
    exmem_wr = 1; exmem_rd = 5; exmem_res = 32'hAAAA;
    memwb_wr = 1; memwb_rd = 5; memwb_res = 32'hBBBB;
    drive(5, 32'h5, 6, 32'h66, 0, 0, ALU_ADD, 0, 3, 1);
    push(32'hAAAA, 32'h66, ALU_ADD, 0, 3, 1);
    xfer();

    // $0 is never forwarded
    #1;
    exmem_wr = 1; exmem_rd = 0; exmem_res = 32'h1234;
    memwb_wr = 0;
    drive(2, 32'h22, 0, 32'h55, 0, 0, ALU_OR, 4, 6, 1);
    push(32'h22, 32'h0, ALU_OR, 4, 6, 1);
    xfer();

    // MEM/WB on rs; immediate wins over an EX/MEM hit on rt
    #1;
    exmem_wr = 1; exmem_rd = 4; exmem_res = 32'h44;
    memwb_wr = 1; memwb_rd = 9; memwb_res = 32'h99;
    drive(9, 32'h1, 4, 32'h2, 32'hFFFF_FFF0, 1, ALU_SLT, 0, 7, 0);
    push(32'h99, 32'hFFFF_FFF0, ALU_SLT, 0, 7, 0);
    xfer();
    step();

    // Hold refresh: dataA picks up a late MEM/WB result while stalled
    exmem_wr = 0; memwb_wr = 0;
    bus.out_ready = 1'b0;
    drive(7, 32'h1, 8, 32'h2, 0, 0, ALU_SUB, 3, 10, 1);
    push(32'h9, 32'h2, ALU_SUB, 3, 10, 1);
    xfer();
    chk("hold_pre_dataA", bus.dataA, 32'h1);
    chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    memwb_wr = 1; memwb_rd = 7; memwb_res = 32'h9;
    step();
    memwb_wr = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_dataA", bus.dataA, 32'h9);
    chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("hold_Signal", {29'd0, bus.Signal}, {29'd0, ALU_SUB});
    step();

    // Flush beats a same-cycle capture and clears out_reg_write
    bus.out_ready = 1'b0;
    drive(3, 32'h3, 3, 32'h3, 0, 0, ALU_AND, 0, 12, 1);
    xfer();
    chk("pre_flush_rw", {31'd0, bus.out_reg_write}, 32'd1);
    step();
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1, 32'h1, 1, 32'h1, 0, 0, ALU_OR, 0, 13, 1);
    #1;
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_rw", {31'd0, bus.out_reg_write}, 32'd0);
    step();

    // Back-to-back: no bubbles, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 1, 2, (i + 1) * 16, 0, 0, sigs[i], i[4:0], i[4:0] + 5'd1, 1);
      push(i + 1, (i + 1) * 16, sigs[i], i[4:0], i[4:0] + 5'd1, 1);
      @(negedge clk);
      chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i > 0) chk("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_valid", {31'd0, bus.out_valid}, 32'd1);
    step();

    // Async reset mid-hold clears everything before the next edge
    bus.out_ready = 1'b0;
    drive(6, 32'h77, 6, 32'h77, 0, 0, ALU_SLL, 9, 14, 1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_dataA", bus.dataA, 32'd0);
    chk("arst_dataB", bus.dataB, 32'd0);
    chk("arst_Signal", {29'd0, bus.Signal}, 32'd0);
    chk("arst_shamt", {27'd0, bus.shamt}, 32'd0);
    chk("arst_rd", {27'd0, bus.out_rd_idx}, 32'd0);
    chk("arst_rw", {31'd0, bus.out_reg_write}, 32'd0);
    #10 rst_n = 1'b1;
    step();
    chk("sb_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
ID/EX-side issue register that produces the operands and control consumed by the ALU: dataA, dataB, Signal and shamt.
- Captures decoded instructions through a valid/ready handshake.
- Resolves EX/MEM and MEM/WB forwarding at capture.
- Keeps held operands coherent while the stage is stalled.
- Supports flush for branch and jump squash.
- Sits between the register-file/decoder and the ALU in the pipelined MIPS-lite CPU.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  squash the held instruction and any capture this cycle.
- in_valid  input  1  decoder presents an instruction.
- in_ready  output  1  stage can accept.
- in_rs_data  input  DW  register-file read of rs.
- in_rt_data  input  DW  register-file read of rt.
- in_imm  input  DW  sign-extended immediate.
- in_use_imm  input  1  dataB takes in_imm instead of rt.
- in_signal  input  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 SLL, 110 SUB, 111 SLT.
- in_shamt  input  5  shift amount.
- in_rs_idx  input  RW  rs register index.
- in_rt_idx  input  RW  rt register index.
- in_rd_idx  input  RW  destination register index.
- in_reg_write  input  1  instruction writes rd.
- exmem_wr  input  1  EX/MEM write enable.
- exmem_rd  input  RW  EX/MEM destination.
- exmem_res  input  DW  EX/MEM result.
- memwb_wr  input  1  MEM/WB write enable.
- memwb_rd  input  RW  MEM/WB destination.
- memwb_res  input  DW  MEM/WB result.
- out_valid  output  1  ALU operands valid.
- out_ready  input  1  EX stage accepts.
- dataA  output  DW  ALU operand A.
- dataB  output  DW  ALU operand B.
- Signal  output  3  ALU control.
- shamt  output  5  shift amount.
- out_rd_idx  output  RW  destination register index.
- out_reg_write  output  1  destination write enable.

Behaviour:
- Reset (async, rst_n=0): out_valid=0; dataA, dataB, Signal, shamt, out_rd_idx, out_reg_write all 0. Internal stored rs/rt indices, use_imm and imm are 0.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on flush.
- Capture: in_valid && in_ready && !flush loads all fields and sets out_valid=1 on the next edge. Latency is one cycle.
- Forward selection for operand X with index idx and register value v:
  - idx==0 → 0. Register $0 is never forwarded and always reads 0.
  - else exmem_wr && exmem_rd==idx → exmem_res.
  - else memwb_wr && memwb_rd==idx → memwb_res.
  - else v.
- dataA = fwd(rs). dataB = in_use_imm ? in_imm : fwd(rt).
- Hold (out_valid && !out_ready): all outputs are held, except that dataA and dataB are re-forwarded every cycle from the stored indices.
  - Re-forwarding uses the same priority as capture, with the currently held dataA/dataB value standing in for v.
  - dataB is not re-forwarded when the stored use_imm is set.
- Drain: out_ready && out_valid with no capture in the same cycle → out_valid=0 next edge. Data outputs keep their last values.
- Simultaneous drain and capture: the new instruction replaces the old one. There is no bubble.
- flush=1: out_valid=0 next edge and in_valid is ignored. Flush takes priority over capture and over hold. out_reg_write clears to 0.
- rst_n asserted mid-hold: everything clears immediately. No partial state survives.
- The block does not detect load-use hazards. The hazard unit must deassert in_valid in that case.

Optional Feature:
- Macro: ALU_ISSUE_PERF_CNT_EN.
- When defined, adds two output ports, both 16-bit saturating counters reset to 0:
  - perf_stall_cyc: increments each cycle with out_valid && !out_ready.
  - perf_fwd_cnt: increments once per capture in which at least one operand is forwarded.
- Counters saturate at 16'hFFFF and do not wrap.
- When not defined, neither port nor counter exists, and the logic is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SLL=3'b011, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - Width constants DW and RW.
- One sub-module, fwd_mux: combinational three-source priority select with the $0 guard. It is instantiated twice for capture and twice for hold re-forwarding.

Test Plan:
- Reset: drive rst_n=0 mid-hold with out_valid=1 → out_valid=0 and all outputs 0 asynchronously, before the next edge.
- Forward priority: in_rs_idx=5, exmem_wr=1, exmem_rd=5, exmem_res=32'hAAAA, memwb_wr=1, memwb_rd=5, memwb_res=32'hBBBB → dataA=32'hAAAA one cycle later.
- $0 guard: in_rt_idx=0, exmem_rd=0, exmem_wr=1, exmem_res=32'h1234 → dataB=0.
- Hold refresh:
  - Capture in_rs_idx=7 with in_rs_data=1, then hold with out_ready=0.
  - Next cycle drive memwb_wr=1, memwb_rd=7, memwb_res=9 → dataA becomes 9 while out_valid stays 1 and Signal is unchanged.
- Flush vs capture: flush=1 and in_valid=1 in the same cycle → out_valid=0 next edge and out_reg_write=0.
- Back-to-back throughput: out_ready=1 and in_valid=1 for 4 cycles with in_signal=010, 110, 111, 011 → Signal follows with one-cycle latency, in_ready stays 1 throughout, and there are no bubbles.
